// File: rtl/line_rasterizer.sv
// rtl/line_rasterizer.sv - Bresenham line rasterizer emitting one pixel write per accepted handshake
//
// Loads a colour and two endpoints while idle, then on a trigger walks the
// line from the lower-major endpoint to the other one, presenting each pixel
// as a byte address in a 1024x1024, 4-byte-per-pixel frame plus the colour.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   LE_color[31:0]              line colour, copied to px_data
//   LE_point[19:0]              point {x[9:0], y[9:0]}
//   LE_color_valid              load colour
//   LE_point0_valid             load P0
//   LE_point1_valid             load P1 (also honoured on the trigger cycle)
//   LE_trigger                  start a line, latches LE_frame
//   LE_frame[31:0]              frame base byte address
//   LE_ready                    high only while idle
//   px_valid / px_ready         pixel write handshake
//   px_addr[31:0]               frame + {y, x, 2'b00}
//   px_data[31:0]               pixel colour
//   line_done                   one-cycle pulse after the last pixel
//
// Optional feature: define LINE_CLIP_EN to suppress pixels with x>=800 or
// y>=600; suppressed pixels still consume one iterator step per cycle.

module line_rasterizer (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] LE_color,
    input  logic [19:0] LE_point,
    input  logic        LE_color_valid,
    input  logic        LE_point0_valid,
    input  logic        LE_point1_valid,
    input  logic        LE_trigger,
    input  logic [31:0] LE_frame,
    output logic        LE_ready,
    output logic        px_valid,
    input  logic        px_ready,
    output logic [31:0] px_addr,
    output logic [31:0] px_data,
    output logic        line_done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SETUP = 2'd1;
    localparam logic [1:0] DRAW  = 2'd2;

    logic [1:0]         state;
    logic [31:0]        color_r;
    logic [19:0]        p0_r;
    logic [19:0]        p1_r;
    logic [31:0]        frame_r;
    logic signed [11:0] err_r;
    logic [9:0]         maj_r;
    logic [9:0]         min_r;
    logic [9:0]         maj_end_r;
    logic [10:0]        dx_r;
    logic [10:0]        dy_r;
    logic               ystep_neg_r;
    logic               steep_r;
    logic               line_done_r;

    // Setup datapath: all values derive from the registered endpoints.
    logic signed [10:0] sx0, sy0, sx1, sy1, ddx, ddy, adx, ady;
    logic               steep_s, swap_s, ystep_neg_s;
    logic [9:0]         a0, b0, a1, b1, ma0, mi0, ma1, mi1;
    logic [10:0]        dx_s, dy_s;

    always_comb begin
        sx0 = {1'b0, p0_r[19:10]};
        sy0 = {1'b0, p0_r[9:0]};
        sx1 = {1'b0, p1_r[19:10]};
        sy1 = {1'b0, p1_r[9:0]};
        ddx = sx1 - sx0;
        ddy = sy1 - sy0;
        adx = ddx[10] ? -ddx : ddx;
        ady = ddy[10] ? -ddy : ddy;
        steep_s = ady > adx;
        // a* is the major coordinate, b* the minor one
        a0 = steep_s ? p0_r[9:0]   : p0_r[19:10];
        b0 = steep_s ? p0_r[19:10] : p0_r[9:0];
        a1 = steep_s ? p1_r[9:0]   : p1_r[19:10];
        b1 = steep_s ? p1_r[19:10] : p1_r[9:0];
        swap_s = a0 > a1;
        ma0 = swap_s ? a1 : a0;
        mi0 = swap_s ? b1 : b0;
        ma1 = swap_s ? a0 : a1;
        mi1 = swap_s ? b0 : b1;
        dx_s = {1'b0, ma1} - {1'b0, ma0};
        dy_s = (mi1 >= mi0) ? ({1'b0, mi1} - {1'b0, mi0}) : ({1'b0, mi0} - {1'b0, mi1});
        ystep_neg_s = mi1 < mi0;
    end

    // Iterator step
    logic signed [11:0] err_dec, err_nxt;
    logic [9:0]         min_nxt;
    logic [9:0]         cur_x, cur_y;
    logic               last_px;
    logic               in_view;
    logic               drawing;
    logic               step;

    always_comb begin
        err_dec = err_r - $signed({1'b0, dy_r});
        err_nxt = err_dec[11] ? (err_dec + $signed({1'b0, dx_r})) : err_dec;
        min_nxt = min_r;
        if (err_dec[11]) begin
            min_nxt = ystep_neg_r ? (min_r - 10'd1) : (min_r + 10'd1);
        end
        cur_x   = steep_r ? min_r : maj_r;
        cur_y   = steep_r ? maj_r : min_r;
        last_px = (maj_r == maj_end_r);
        drawing = (state == DRAW);
`ifdef LINE_CLIP_EN
        in_view = (cur_x < 10'd800) && (cur_y < 10'd600);
`else
        in_view = 1'b1;
`endif
        // Off-screen pixels advance without waiting for the consumer.
        step = drawing && (in_view ? px_ready : 1'b1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            color_r     <= '0;
            p0_r        <= '0;
            p1_r        <= '0;
            frame_r     <= '0;
            err_r       <= '0;
            maj_r       <= '0;
            min_r       <= '0;
            maj_end_r   <= '0;
            dx_r        <= '0;
            dy_r        <= '0;
            ystep_neg_r <= 1'b0;
            steep_r     <= 1'b0;
            line_done_r <= 1'b0;
        end else begin
            line_done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (LE_color_valid)  color_r <= LE_color;
                    if (LE_point0_valid) p0_r    <= LE_point;
                    if (LE_point1_valid) p1_r    <= LE_point;
                    if (LE_trigger) begin
                        frame_r <= LE_frame;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    maj_r       <= ma0;
                    min_r       <= mi0;
                    maj_end_r   <= ma1;
                    dx_r        <= dx_s;
                    dy_r        <= dy_s;
                    ystep_neg_r <= ystep_neg_s;
                    steep_r     <= steep_s;
                    err_r       <= $signed({2'b00, dx_s[10:1]});
                    state       <= DRAW;
                end
                DRAW: begin
                    if (step) begin
                        if (last_px) begin
                            state       <= IDLE;
                            line_done_r <= 1'b1;
                        end else begin
                            maj_r <= maj_r + 10'd1;
                            min_r <= min_nxt;
                            err_r <= err_nxt;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign LE_ready  = (state == IDLE);
    assign px_valid  = drawing && in_view;
    assign px_addr   = px_valid ? (frame_r + {10'd0, cur_y, cur_x, 2'b00}) : 32'd0;
    assign px_data   = px_valid ? color_r : 32'd0;
    assign line_done = line_done_r;

endmodule

// File: tb/tb_line_rasterizer.sv
// tb/tb_line_rasterizer.sv - self-checking bench for line_rasterizer against a Bresenham reference model

module tb_line_rasterizer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] LE_color;
    logic [19:0] LE_point;
    logic        LE_color_valid;
    logic        LE_point0_valid;
    logic        LE_point1_valid;
    logic        LE_trigger;
    logic [31:0] LE_frame;
    logic        LE_ready;
    logic        px_valid;
    logic        px_ready;
    logic [31:0] px_addr;
    logic [31:0] px_data;
    logic        line_done;

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_q[$];
    logic        exp_first;

    always #5 clk = ~clk;

    line_rasterizer dut (
        .clk(clk), .rst(rst),
        .LE_color(LE_color), .LE_point(LE_point),
        .LE_color_valid(LE_color_valid), .LE_point0_valid(LE_point0_valid),
        .LE_point1_valid(LE_point1_valid), .LE_trigger(LE_trigger),
        .LE_frame(LE_frame), .LE_ready(LE_ready),
        .px_valid(px_valid), .px_ready(px_ready),
        .px_addr(px_addr), .px_data(px_data), .line_done(line_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference: textbook Bresenham over integers, yielding byte addresses in order.
    task automatic build_model(input int ix0, input int iy0, input int ix1, input int iy1,
                               input logic [31:0] frame);
        int x0, y0, x1, y1, t, dx, dy, err, ys, y, px, py;
        bit steep, vis;
        x0 = ix0; y0 = iy0; x1 = ix1; y1 = iy1;
        exp_q.delete();
        steep = ((y1 > y0 ? y1 - y0 : y0 - y1) > (x1 > x0 ? x1 - x0 : x0 - x1));
        if (steep) begin
            t = x0; x0 = y0; y0 = t;
            t = x1; x1 = y1; y1 = t;
        end
        if (x0 > x1) begin
            t = x0; x0 = x1; x1 = t;
            t = y0; y0 = y1; y1 = t;
        end
        dx  = x1 - x0;
        dy  = (y1 > y0) ? y1 - y0 : y0 - y1;
        err = dx / 2;
        ys  = (y0 < y1) ? 1 : -1;
        y   = y0;
        for (int x = x0; x <= x1; x++) begin
            px = steep ? y : x;
            py = steep ? x : y;
`ifdef LINE_CLIP_EN
            vis = (px < 800) && (py < 600);
`else
            vis = 1'b1;
`endif
            if (x == x0) exp_first = vis;
            if (vis) exp_q.push_back(frame + 32'(py * 4096 + px * 4));
            err = err - dy;
            if (err < 0) begin
                y   = y + ys;
                err = err + dx;
            end
        end
    endtask

    task automatic clear_inputs();
        LE_color_valid  = 1'b0;
        LE_point0_valid = 1'b0;
        LE_point1_valid = 1'b0;
        LE_trigger      = 1'b0;
    endtask

    task automatic drive_noise();
        LE_color        = $urandom;
        LE_point        = 20'($urandom);
        LE_frame        = $urandom;
        LE_color_valid  = 1'b1;
        LE_point0_valid = 1'b1;
        LE_point1_valid = 1'b1;
        LE_trigger      = 1'b1;
    endtask

    function automatic logic rdy(input int mode, input int c);
        if (mode == 1) return ($urandom_range(0, 3) != 0);
        if (mode == 2) return !(c >= 1 && c <= 3);
        return 1'b1;
    endfunction

    // Loads colour and P0, then triggers with P1 supplied on the trigger cycle.
    task automatic load_trigger(input int x0, input int y0, input int x1, input int y1,
                                input logic [31:0] color, input logic [31:0] frame);
        LE_color = color; LE_color_valid = 1'b1;
        LE_point = {10'(x0), 10'(y0)}; LE_point0_valid = 1'b1;
        @(posedge clk); #1;
        clear_inputs();
        LE_point = {10'(x1), 10'(y1)}; LE_point1_valid = 1'b1;
        LE_frame = frame; LE_trigger = 1'b1;
        @(posedge clk); #1;
        clear_inputs();
    endtask

    task automatic trigger_only(input logic [31:0] frame);
        LE_frame = frame; LE_trigger = 1'b1;
        @(posedge clk); #1;
        clear_inputs();
    endtask

    // Called right after the trigger edge; walks the line and checks each pixel.
    task automatic draw_check(input logic [31:0] color, input int mode, input bit noise);
        int idx, hold_cnt;
        bit done, prev_stall;
        logic [31:0] prev_addr;
        idx = 0; hold_cnt = 0; done = 0; prev_stall = 0; prev_addr = '0;
        if (noise) drive_noise();
        @(negedge clk);
        chk("setup_ready", LE_ready, 1'b0);
        chk("setup_valid", px_valid, 1'b0);
        @(posedge clk); #1;
        px_ready = rdy(mode, 0);
        if (noise) drive_noise(); else clear_inputs();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (c == 0) chk("first_valid", px_valid, exp_first);
            if (prev_stall) chk("hold_addr", px_addr, prev_addr);
            if (px_valid) begin
                if (idx < exp_q.size()) chk("px_addr", px_addr, exp_q[idx]);
                else chk("extra_pixel", px_addr, 32'hFFFF_FFFF);
                chk("px_data", px_data, color);
                if (exp_q.size() > 1 && px_addr === exp_q[1]) hold_cnt++;
            end
            prev_stall = px_valid && !px_ready;
            prev_addr  = px_addr;
            if (px_valid && px_ready) idx++;
            if (line_done) begin
                done = 1;
                break;
            end
            @(posedge clk); #1;
            px_ready = rdy(mode, c + 1);
            if (noise && idx < exp_q.size()) drive_noise(); else clear_inputs();
        end
        clear_inputs();
        chk("line_done_seen", 32'(done), 32'd1);
        chk("pixel_count", idx, exp_q.size());
        if (mode == 2) chk("stall_hold_cycles", hold_cnt, 4);
        @(posedge clk); #1;
        @(negedge clk);
        chk("done_pulse_width", line_done, 1'b0);
        chk("idle_ready", LE_ready, 1'b1);
        @(posedge clk); #1;
    endtask

    initial begin
        int x0, y0, x1, y1, seen;
        logic [31:0] col, frm;
        rst = 1'b1; px_ready = 1'b0;
        LE_color = '0; LE_point = '0; LE_frame = '0;
        clear_inputs();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_px_valid", px_valid, 1'b0);
        chk("rst_line_done", line_done, 1'b0);
        chk("rst_px_addr", px_addr, 32'd0);
        chk("rst_px_data", px_data, 32'd0);
        chk("rst_ready", LE_ready, 1'b1);
        @(posedge clk); #1;

        // Horizontal
        build_model(10, 5, 13, 5, 32'h1040_0000);
        chk("model_horiz_first", exp_q[0], 32'h1040_5028);
        load_trigger(10, 5, 13, 5, 32'h00FF_0000, 32'h1040_0000);
        draw_check(32'h00FF_0000, 0, 0);

        // Diagonal
        build_model(0, 0, 3, 3, 32'h1040_0000);
        load_trigger(0, 0, 3, 3, 32'h0000_00FF, 32'h1040_0000);
        draw_check(32'h0000_00FF, 0, 0);

        // Steep reversed
        build_model(2, 7, 1, 3, 32'h1040_0000);
        load_trigger(2, 7, 1, 3, 32'h1234_5678, 32'h1040_0000);
        draw_check(32'h1234_5678, 0, 0);

        // Backpressure on the second pixel
        build_model(10, 5, 13, 5, 32'h1040_0000);
        load_trigger(10, 5, 13, 5, 32'h00FF_0000, 32'h1040_0000);
        draw_check(32'h00FF_0000, 2, 0);

        // Degenerate point
        build_model(0, 0, 0, 0, 32'h1040_0000);
        load_trigger(0, 0, 0, 0, 32'hCAFE_0001, 32'h1040_0000);
        draw_check(32'hCAFE_0001, 0, 0);

        // Strobes while busy must not affect the retained line
        build_model(3, 9, 17, 2, 32'h2000_0000);
        load_trigger(3, 9, 17, 2, 32'h0BAD_F00D, 32'h2000_0000);
        draw_check(32'h0BAD_F00D, 1, 1);
        build_model(3, 9, 17, 2, 32'h3000_0000);
        trigger_only(32'h3000_0000);
        draw_check(32'h0BAD_F00D, 1, 0);

        // Random lines with random backpressure
        for (int n = 0; n < 10; n++) begin
            if (n < 6) begin
                x0 = $urandom_range(0, 63); y0 = $urandom_range(0, 63);
                x1 = $urandom_range(0, 63); y1 = $urandom_range(0, 63);
            end else begin
                x0 = $urandom_range(0, 1023); y0 = $urandom_range(0, 1023);
                x1 = $urandom_range(0, 1023); y1 = $urandom_range(0, 1023);
            end
            col = $urandom; frm = $urandom;
            build_model(x0, y0, x1, y1, frm);
            load_trigger(x0, y0, x1, y1, col, frm);
            draw_check(col, 1, 0);
        end

        // Reset mid-line after the second pixel
        load_trigger(0, 0, 40, 0, 32'h5555_AAAA, 32'h1040_0000);
        px_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 20 && seen < 2; c++) begin
            @(negedge clk);
            if (px_valid) seen++;
        end
        chk("pre_reset_pixels", seen, 2);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_px_valid", px_valid, 1'b0);
        chk("midrst_ready", LE_ready, 1'b1);
        chk("midrst_px_addr", px_addr, 32'd0);
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (px_valid || line_done) seen++;
        end
        chk("midrst_quiet", seen, 0);
        @(posedge clk); #1;

        // Reset cleared colour and points: an unloaded trigger draws one zero pixel
        build_model(0, 0, 0, 0, 32'h0400_0000);
        trigger_only(32'h0400_0000);
        draw_check(32'h0000_0000, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
